// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        RESP,
        SUPPLY
    } fetch_state_t;

    // Transaction codes shared with the rest of the system bus (Sysbus.defs).
    localparam logic        SYSBUS_READ   = 1'b1;
    localparam logic [3:0]  SYSBUS_MEMORY = 4'b0001;

    // Memory read with a zero sub-tag.
    localparam logic [12:0] FETCH_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

    localparam int unsigned LINE_BYTES      = 64;
    localparam int unsigned INSTRS_PER_LINE = 16;

    // Aligned line address containing byte address a.
    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a & ~(64'(LINE_BYTES) - 64'd1);
    endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One cache line of fetched instructions: beat-wide write port,
// instruction-wide combinational read port.
module fetch_line_buffer
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                  clk,
    input  logic                                  wr_en,
    input  logic [$clog2(LINE_BEATS)-1:0]         wr_idx,
    input  logic [BUS_DATA_WIDTH-1:0]             wr_data,
    input  logic [$clog2(INSTRS_PER_LINE)-1:0]    rd_off,
    output logic [31:0]                           rd_word
);

    logic [BUS_DATA_WIDTH-1:0] mem_q [LINE_BEATS];
    logic [BUS_DATA_WIDTH-1:0] mem_d [LINE_BEATS];
    logic [BUS_DATA_WIDTH-1:0] rd_beat;

    // Next-state: overwrite the addressed beat when enabled.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // Line storage; contents are only meaningful after a full fill, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Instruction 2k lives in the low half of beat k, 2k+1 in the high half.
    always_comb begin
        rd_beat = mem_q[rd_off[3:1]];
        rd_word = rd_off[0] ? rd_beat[63:32] : rd_beat[31:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one 64-byte line at a time over the
// system bus, buffers it, and streams 32-bit instructions to the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic                      bus_respack,
    output logic                      instr_valid,
    output logic [31:0]               instruction,
    output logic [63:0]               instr_pc,
    input  logic                      instr_ready
);

    localparam int CNT_W = $clog2(LINE_BEATS);

    fetch_state_t     state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [63:0]      line_addr_q, line_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             discard_q, discard_d;

    logic [63:0]      redir_pc;
    logic             last_beat;
    logic             buf_we;
    logic [31:0]      buf_word;

    assign redir_pc  = redirect_pc & ~64'h3;
    assign last_beat = (cnt_q == CNT_W'(LINE_BEATS - 1));

    fetch_line_buffer #(
        .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
        .LINE_BEATS     (LINE_BEATS)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_idx  (cnt_q),
        .wr_data (bus_resp),
        .rd_off  (pc_q[5:2]),
        .rd_word (buf_word)
    );

    // Next-state: FSM transitions, pc tracking, beat counting and discard.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        line_addr_d = line_addr_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;

        unique case (state_q)
            REQ: begin
                if (bus_reqack) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end
                // The request on the bus keeps its address; its data is dropped.
                if (redirect_valid) begin
                    pc_d      = redir_pc;
                    discard_d = 1'b1;
                end
            end
            RESP: begin
                if (bus_respcyc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        cnt_d = '0;
                        if (discard_q || redirect_valid) begin
                            state_d   = REQ;
                            discard_d = 1'b0;
                        end else begin
                            state_d = SUPPLY;
                        end
                    end
                end
                // A redirect on the final beat is resolved by the re-request above.
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (!(bus_respcyc && last_beat)) begin
                        discard_d = 1'b1;
                    end
                end
            end
            SUPPLY: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = REQ;
                end else if (instr_ready) begin
                    pc_d = pc_q + 64'd4;
                    if (pc_q[5:2] == 4'(INSTRS_PER_LINE - 1)) begin
                        state_d = REQ;
                    end
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        // Capture the request address once, on entry to REQ, so it stays stable.
        if ((state_d == REQ) && (state_q != REQ)) begin
            line_addr_d = line_of(pc_d);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= REQ;
            pc_q        <= entry;
            line_addr_q <= line_of(entry);
            cnt_q       <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            line_addr_q <= line_addr_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
        end
    end

    // Outputs: decoded from state, forced to zero while reset is asserted.
    always_comb begin
        bus_reqcyc  = reset && (state_q == REQ);
        bus_req     = bus_reqcyc ? line_addr_q : 64'd0;
        bus_reqtag  = BUS_TAG_WIDTH'(FETCH_TAG);
        bus_respack = reset && (state_q == RESP) && bus_respcyc;
        buf_we      = bus_respack;
        instr_valid = reset && (state_q == SUPPLY);
        instruction = instr_valid ? buf_word : 32'd0;
        instr_pc    = instr_valid ? pc_q : 64'd0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a bus memory agent serves lines from an
// address-hash memory and an instruction-stream model predicts the decoder view.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] entry = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic        bus_respack;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic        instr_ready = 1'b0;

    fetch_unit #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .LINE_BEATS     (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_respack    (bus_respack),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs
    int          ack_pct, resp_pct, ready_mode, redir_pct, force_mode;
    bit          gap_mode;
    logic [63:0] force_pc;

    // Bus agent
    bit          ag_busy;
    logic [63:0] ag_addr;
    int          ag_idx, gap_cnt;

    // Instruction-stream model
    logic [63:0] exp_pc;
    bit          disc, exp_rq, first_cycle, prev_pend, prev_stall, last_valid;
    int          exp_v, supply_cycles;
    logic [63:0] prev_req, prev_pc;
    logic [31:0] prev_ins;
    logic [63:0] req_log [$];
    logic [63:0] pc_log [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] line_addr(input logic [63:0] a);
        return {a[63:6], 6'b0};
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] h;
        h = (a >> 2) * 64'h9E37_79B9_7F4A_7C15;
        return h[63:32];
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a, input int k);
        return {mem_word(a + 64'(8 * k) + 64'd4), mem_word(a + 64'(8 * k))};
    endfunction

    function automatic logic [63:0] q_at(input logic [63:0] q [$], input int i);
        if (i < q.size()) return q[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic do_reset(input logic [63:0] e);
        @(negedge clk);
        reset          = 1'b0;
        entry          = e;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        bus_reqack     = 1'b1;
        bus_respcyc    = 1'b1;
        bus_resp       = '1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        check_eq("rst_respack", 64'(bus_respack), 64'd0);
        check_eq("rst_valid", 64'(instr_valid), 64'd0);
        check_eq("rst_instruction", 64'(instruction), 64'd0);
        check_eq("rst_instr_pc", instr_pc, 64'd0);
        reset       = 1'b1;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        exp_pc      = e;
        disc        = 1'b0;
        exp_v       = -1;
        exp_rq      = 1'b0;
        prev_pend   = 1'b0;
        prev_stall  = 1'b0;
        last_valid  = 1'b0;
        ag_busy     = 1'b0;
        ag_idx      = 0;
        first_cycle = 1'b1;
        supply_cycles = 0;
        req_log.delete();
        pc_log.delete();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step();
        bit hs_req, hs_beat, fire, lb, forced;
        @(negedge clk);
        forced         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (force_mode == 1) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_mode     = 0;
            forced         = 1'b1;
        end else if (redir_pct != 0 && $urandom_range(99) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = {$urandom(), $urandom()};
        end
        case (ready_mode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = ~instr_ready;
            2:       instr_ready = 1'b0;
            default: instr_ready = 1'($urandom_range(1));
        endcase
        bus_respcyc = 1'b0;
        bus_resp    = {$urandom(), $urandom()};
        if (ag_busy) begin
            if (gap_mode && ag_idx == 4 && gap_cnt < 3) begin
                gap_cnt++;
            end else if ($urandom_range(99) < resp_pct) begin
                bus_respcyc = 1'b1;
                bus_resp    = beat_data(ag_addr, ag_idx);
            end
        end
        #1;
        bus_reqack = bus_reqcyc && !ag_busy && ($urandom_range(99) < ack_pct);
        if (force_mode == 2 && instr_valid && instr_ready) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_mode     = 0;
            forced         = 1'b1;
        end
        #1;

        if (first_cycle) begin
            check_eq("first_reqcyc", 64'(bus_reqcyc), 64'd1);
            check_eq("first_req", bus_req, line_addr(exp_pc));
            first_cycle = 1'b0;
        end
        if (exp_v >= 0) check_eq("valid_seq", 64'(instr_valid), 64'(exp_v));
        if (exp_rq) check_eq("reqcyc_seq", 64'(bus_reqcyc), 64'd1);
        exp_v  = -1;
        exp_rq = 1'b0;
        if (prev_pend) begin
            check_eq("req_hold_cyc", 64'(bus_reqcyc), 64'd1);
            check_eq("req_hold_addr", bus_req, prev_req);
        end
        if (prev_stall) begin
            check_eq("stall_valid", 64'(instr_valid), 64'd1);
            check_eq("stall_pc", instr_pc, prev_pc);
            check_eq("stall_ins", 64'(instruction), 64'(prev_ins));
        end
        check_eq("respack", 64'(bus_respack), 64'(bus_respcyc && ag_busy));
        if (bus_reqcyc) check_eq("reqtag", 64'(bus_reqtag), 64'h1100);
        if (instr_valid) begin
            supply_cycles++;
            check_eq("instr_pc", instr_pc, exp_pc);
            check_eq("instruction", 64'(instruction), 64'(mem_word(exp_pc)));
        end

        hs_req  = bus_reqcyc && bus_reqack;
        hs_beat = bus_respcyc && bus_respack;
        fire    = instr_valid && instr_ready;
        lb      = hs_beat && ag_idx == 7;
        if (forced) begin
            req_log.delete();
            pc_log.delete();
        end
        if (hs_req) begin
            if (!disc && !redirect_valid) check_eq("req_addr", bus_req, line_addr(exp_pc));
            req_log.push_back(bus_req);
            ag_busy = 1'b1;
            ag_addr = bus_req;
            ag_idx  = 0;
            gap_cnt = 0;
        end
        if (hs_beat) begin
            ag_idx++;
            if (ag_idx == 8) ag_busy = 1'b0;
        end
        prev_pend  = bus_reqcyc && !bus_reqack;
        prev_req   = bus_req;
        prev_stall = instr_valid && !instr_ready && !redirect_valid;
        prev_pc    = instr_pc;
        prev_ins   = instruction;
        last_valid = instr_valid;

        if (lb) begin
            exp_v  = (disc || redirect_valid) ? 0 : 1;
            exp_rq = (exp_v == 0);
            disc   = 1'b0;
        end
        if (redirect_valid) begin
            if (instr_valid) begin
                exp_v  = 0;
                exp_rq = 1'b1;
            end else if (!lb) begin
                disc = 1'b1;
            end
            exp_pc = redirect_pc & ~64'h3;
        end else if (fire) begin
            pc_log.push_back(exp_pc);
            if (exp_pc[5:2] == 4'hF) begin
                exp_v  = 0;
                exp_rq = 1'b1;
            end
            exp_pc = exp_pc + 64'd4;
        end
    endtask

    initial begin
        ack_pct    = 100;
        resp_pct   = 100;
        ready_mode = 0;
        redir_pct  = 0;
        force_mode = 0;
        force_pc   = '0;
        gap_mode   = 1'b0;

        // Entry at a line start, full line, ready tied high
        do_reset(64'h1000);
        for (int i = 0; i < 300 && req_log.size() < 2; i++) step();
        check_eq("p1_nreq", 64'(req_log.size()), 64'd2);
        check_eq("p1_req0", q_at(req_log, 0), 64'h1000);
        check_eq("p1_req1", q_at(req_log, 1), 64'h1040);
        check_eq("p1_ninstr", 64'(pc_log.size()), 64'd16);
        check_eq("p1_pc_first", q_at(pc_log, 0), 64'h1000);
        check_eq("p1_pc_last", q_at(pc_log, 15), 64'h103C);
        check_eq("p1_throughput", 64'(supply_cycles), 64'd16);

        // Mid-line entry
        do_reset(64'h2038);
        for (int i = 0; i < 300 && req_log.size() < 2; i++) step();
        check_eq("p2_req0", q_at(req_log, 0), 64'h2000);
        check_eq("p2_req1", q_at(req_log, 1), 64'h2040);
        check_eq("p2_ninstr", 64'(pc_log.size()), 64'd2);
        check_eq("p2_pc_first", q_at(pc_log, 0), 64'h2038);

        // Backpressure: toggling ready, then a 5-cycle stall
        do_reset(64'h4000);
        ack_pct    = 60;
        resp_pct   = 70;
        ready_mode = 1;
        for (int i = 0; i < 60; i++) step();
        for (int i = 0; i < 200 && !last_valid; i++) step();
        ready_mode = 2;
        for (int i = 0; i < 5; i++) step();
        ready_mode = 0;
        for (int i = 0; i < 100; i++) step();
        check_eq("p3_progress", 64'(pc_log.size() > 20), 64'd1);

        // Beat gaps between beats 3 and 4
        ack_pct  = 100;
        resp_pct = 100;
        gap_mode = 1'b1;
        do_reset(64'h5000);
        for (int i = 0; i < 300 && pc_log.size() < 16; i++) step();
        check_eq("p4_ninstr", 64'(pc_log.size()), 64'd16);
        gap_mode = 1'b0;

        // Redirect during RESP after beat 2
        do_reset(64'h5400);
        for (int i = 0; i < 100 && !(ag_busy && ag_idx == 3); i++) step();
        force_pc   = 64'h3004;
        force_mode = 1;
        for (int i = 0; i < 300 && (force_mode != 0 || pc_log.size() < 1); i++) step();
        check_eq("p5_req0", q_at(req_log, 0), 64'h3000);
        check_eq("p5_pc_first", q_at(pc_log, 0), 64'h3004);

        // Redirect coincident with a handshake in SUPPLY, then reset mid-RESP
        do_reset(64'h6000);
        force_pc   = 64'h700B;
        force_mode = 2;
        for (int i = 0; i < 300 && (force_mode != 0 || pc_log.size() < 1); i++) step();
        check_eq("p6_req0", q_at(req_log, 0), 64'h7000);
        check_eq("p6_pc_first", q_at(pc_log, 0), 64'h7008);
        for (int i = 0; i < 300 && !(ag_busy && ag_idx >= 2); i++) step();
        check_eq("p6_in_resp", 64'(ag_busy), 64'd1);
        do_reset(64'h6100);
        for (int i = 0; i < 300 && pc_log.size() < 1; i++) step();
        check_eq("p6_req_after_rst", q_at(req_log, 0), 64'h6100);
        check_eq("p6_pc_after_rst", q_at(pc_log, 0), 64'h6100);

        // pc wrap at the top of the address space
        do_reset(64'hFFFF_FFFF_FFFF_FFF8);
        for (int i = 0; i < 300 && req_log.size() < 2; i++) step();
        check_eq("p7_req0", q_at(req_log, 0), 64'hFFFF_FFFF_FFFF_FFC0);
        check_eq("p7_req1", q_at(req_log, 1), 64'h0);
        check_eq("p7_ninstr", 64'(pc_log.size()), 64'd2);

        // Random soak with redirects, gaps and backpressure
        ack_pct    = 50;
        resp_pct   = 70;
        ready_mode = 3;
        redir_pct  = 3;
        for (int i = 0; i < 3000; i++) step();
        redir_pct = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
